// File: rtl/seg_disp_ctrl_pkg.sv
// Shared types and constants for the seven-segment display write/scan path.
package seg_disp_ctrl_pkg;

    localparam int unsigned DISP_W = 32;
    localparam int unsigned PORT0  = 0;
    localparam int unsigned PORT1  = 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STROBE = 2'd1,
        ST_HOLD   = 2'd2
    } seg_state_e;

    // Fixed priority: port 0 beats port 1.
    function automatic logic [1:0] pick_fixed(input logic [1:0] r);
        logic [1:0] g;
        g = '0;
        if (r[PORT0])
            g[PORT0] = 1'b1;
        else if (r[PORT1])
            g[PORT1] = 1'b1;
        return g;
    endfunction

endpackage

// File: rtl/seg_disp_ctrl_scan_div.sv
// Programmable prescaler and 2-bit digit scan index for the display driver.
module seg_scan_div
    import seg_disp_ctrl_pkg::*;
#(
    parameter int unsigned DIV_W = 17
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             scan_en,
    input  logic [DIV_W-1:0] div_lim,
    output logic [1:0]       Scanning
);

    logic [DIV_W-1:0] cnt_q;
    logic [1:0]       scan_q;

    // >= so that lowering div_lim below the running count ends the dwell next cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            scan_q <= '0;
        end else if (scan_en) begin
            if (cnt_q >= div_lim) begin
                cnt_q  <= '0;
                scan_q <= scan_q + 2'd1;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign Scanning = scan_q;

endmodule

// File: rtl/seg_disp_ctrl.sv
// Two-port arbiter and write-strobe sequencer for the display latch, plus scan index.
// Define SEG_ARB_RR_EN for round-robin tie breaking; otherwise port 0 has fixed priority.
module seg_disp_ctrl
    import seg_disp_ctrl_pkg::*;
#(
    parameter int unsigned DIV_W = 17
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        req,
    input  logic [DISP_W-1:0] data0,
    input  logic [DISP_W-1:0] data1,
    output logic [1:0]        gnt,
    output logic              busy,
    output logic [DISP_W-1:0] disp_num,
    output logic              wseg,
    input  logic              scan_en,
    input  logic [DIV_W-1:0]  div_lim,
    output logic [1:0]        Scanning
);

    seg_state_e        state_q, state_d;
    logic [1:0]        win;
    logic [DISP_W-1:0] disp_q;

`ifdef SEG_ARB_RR_EN
    logic rr_ptr_q;

    // Pointer holds the last granted port; on a tie the other port wins.
    always_comb begin
        win = pick_fixed(req);
        if (req == 2'b11)
            win = rr_ptr_q ? 2'b01 : 2'b10;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            rr_ptr_q <= 1'b1;
        else if (gnt != 2'b00)
            rr_ptr_q <= gnt[PORT1];
    end
`else
    always_comb begin
        win = pick_fixed(req);
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_q <= ST_IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        gnt     = '0;
        wseg    = 1'b0;
        busy    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req != 2'b00) begin
                    gnt     = win;
                    state_d = ST_STROBE;
                end
            end
            ST_STROBE: begin
                wseg    = 1'b1;
                busy    = 1'b1;
                state_d = ST_HOLD;
            end
            ST_HOLD: begin
                busy    = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Data only changes on a grant, so it is stable through STROBE and HOLD.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            disp_q <= '0;
        else if (gnt[PORT0])
            disp_q <= data0;
        else if (gnt[PORT1])
            disp_q <= data1;
    end

    assign disp_num = disp_q;

    seg_scan_div #(
        .DIV_W(DIV_W)
    ) u_scan (
        .clk     (clk),
        .rst_n   (rst_n),
        .scan_en (scan_en),
        .div_lim (div_lim),
        .Scanning(Scanning)
    );

endmodule

// File: doc/seg_disp_ctrl.md
# seg_disp_ctrl

Sequencer and arbiter for the 4-digit seven-segment display path. Shares the 32-bit display value latch between two requesters (CPU bus port 0, debug/switch port 1) with a req/gnt handshake. Issues the write strobe with the setup/hold the falling-edge-triggered display latch needs, and generates the 2-bit digit scan index from a programmable prescaler. Sits between the bus/debug logic and the display driver, feeding its `d_t_seg`, `wseg` and `Scanning` inputs.

## Interface
- `DIV_W`, default 17: prescaler width. Max dwell per digit is 2^DIV_W cycles.
- `clk`  in  1: system clock, all logic on rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `req`  in  2: write request per port. Held high with data stable until `gnt`.
- `data0`  in  32: port 0 write value.
- `data1`  in  32: port 1 write value.
- `gnt`  out  2: one-hot, one-cycle acknowledge. Data of the granted port is captured that cycle.
- `busy`  out  1: high while a write sequence is in progress.
- `disp_num`  out  32: value driven to the display latch data input.
- `wseg`  out  1: display latch write strobe. The latch samples on the falling edge.
- `scan_en`  in  1: 1 = scan runs; 0 = prescaler and scan index frozen.
- `div_lim`  in  DIV_W: terminal count. Dwell per digit is `div_lim`+1 cycles.
- `Scanning`  out  2: digit index 0..3, to the display driver.

## Operation
- **Reset values:** `gnt`=0, `busy`=0, `wseg`=0, `disp_num`=0, `Scanning`=0, prescaler=0, FSM=IDLE, RR pointer=1.
- **FSM states:** IDLE, STROBE, HOLD.
- **IDLE:**
  - If any `req` is high: pick a winner, pulse its `gnt` bit, load `disp_num` from its data, go to STROBE.
  - Otherwise stay in IDLE.
- **STROBE:** `wseg`=1, `busy`=1, `disp_num` held. Next state HOLD.
- **HOLD:** `wseg`=0, `busy`=1, `disp_num` held. This keeps data stable across the strobe's falling edge. Next state IDLE.
- **Arbitration:** only evaluated in IDLE. `req` is ignored in STROBE/HOLD, with no queueing. A port still requesting is re-arbitrated on return to IDLE.
- **Requester rule:** drop `req` in the cycle after `gnt`. A `req` still high then is treated as a new request.
- **Write rate:** at most one write per 3 cycles.
- **Prescaler:**
  - While `scan_en`=1, count 0..`div_lim`.
  - When count >= `div_lim`: clear the count and set `Scanning` to `Scanning`+1 mod 4 (3 wraps to 0).
  - The >= compare makes a `div_lim` lowered below the current count terminate on the next cycle.
  - `div_lim`=0 advances `Scanning` every cycle.
- **Independence:** scan and write paths are independent. A write never stalls or resets the scan.

## Timing
- **Write path:** `req` high in cycle T (IDLE):
  - `gnt` high in T.
  - `disp_num` updated at the T+1 edge.
  - `wseg` high T+1 only.
  - `busy` high T+1..T+2.
  - Earliest next `gnt` is T+3.
- **Scan path:** with `scan_en` high, `Scanning` changes exactly every `div_lim`+1 cycles.
- **`scan_en` deasserted:** freezes both count and `Scanning` from the next edge. Reasserting resumes from the frozen count.
- **Reset mid-sequence:** `wseg` and `disp_num` clear together and asynchronously. Any strobe falling edge caused by reset therefore latches 0. No `gnt` is reissued.
- **Both requests in the same IDLE cycle:** exactly one `gnt` bit. The loser sees no `gnt` and keeps requesting.

## Configuration
- `SEG_ARB_RR_EN` defined:
  - Round-robin arbitration. The pointer records the last granted port.
  - On a tie the other port wins. Reset pointer=1, so port 0 wins the first tie.
  - The pointer updates only on a grant.
- `SEG_ARB_RR_EN` undefined:
  - Fixed priority, port 0 always wins ties.
  - No pointer register.

## Structure
- **Shared package:**
  - FSM state encoding (IDLE=2'd0, STROBE=2'd1, HOLD=2'd2).
  - Port index constants.
  - Display data width constant (32).
- **Sub-module:** `seg_scan_div`, holding the prescaler plus the 2-bit scan counter. Inputs `clk`, `rst_n`, `scan_en`, `div_lim`; output `Scanning`.
- **Top level:** arbiter and write FSM.

## Test plan
- **Reset scan:** reset, then `scan_en`=1, `div_lim`=3 → `Scanning` steps 0,1,2,3,0 every 4 cycles. Drop `scan_en` for 10 cycles → value held.
- **Single write:** `req`=01, `data0`=0x1234ABCD → `gnt`=01 same cycle, `wseg` high exactly 1 cycle, `disp_num`=0x1234ABCD from T+1, `busy` 2 cycles.
- **Tie, RR enabled:**
  - `req`=11 held continuously, `data0`=0xAAAA0000, `data1`=0x0000BBBB.
  - Grants alternate 01,10,01 at T, T+3, T+6.
  - `disp_num` alternates accordingly.
- **Tie, RR disabled:** same stimulus → `gnt`=01 every 3 cycles, port 1 never granted.
- **Busy window:** `req`=10 raised at T+1 while busy from a port 0 grant at T → `gnt`=10 at T+3, not earlier.
- **Reset mid-sequence:** assert `rst_n`=0 during STROBE → `wseg`=0 and `disp_num`=0 immediately. After release: `Scanning`=0, FSM in IDLE, first tie granted to port 0.
